// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter that forwards whole packets, one byte at a time,
// to a UART transmitter, releasing the grant on packet end or requester stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [1:0] gnt,
  output logic       pkt_done,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    HOLD    = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;
  logic             last_q, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_start_nxt;
  logic             req0_ready_nxt;
  logic             req1_ready_nxt;
  logic [1:0]       gnt_nxt;
  logic             pkt_done_nxt;
  logic             timeout_err_nxt;

  // Granted requester's payload; only meaningful while gnt is non-zero.
  logic       g_valid;
  logic [7:0] g_data;
  logic       g_last;

  assign g_valid = gnt[1] ? req1_valid : req0_valid;
  assign g_data  = gnt[1] ? req1_data  : req0_data;
  assign g_last  = gnt[1] ? req1_last  : req0_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      gnt         <= 2'b00;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      last_q      <= last_nxt;
      cnt         <= cnt_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      req0_ready  <= req0_ready_nxt;
      req1_ready  <= req1_ready_nxt;
      gnt         <= gnt_nxt;
      pkt_done    <= pkt_done_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    last_nxt        = last_q;
    cnt_nxt         = cnt;
    tx_data_nxt     = tx_data;
    tx_start_nxt    = 1'b0;
    req0_ready_nxt  = 1'b0;
    req1_ready_nxt  = 1'b0;
    gnt_nxt         = gnt;
    pkt_done_nxt    = 1'b0;
    timeout_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en && (req0_valid || req1_valid)) begin
          // On contention the pointer picks; ptr=0 favours requester 0.
          if (req0_valid && (!req1_valid || !ptr)) gnt_nxt = 2'b01;
          else                                     gnt_nxt = 2'b10;
          state_nxt = SEND;
        end else begin
          gnt_nxt = 2'b00;
        end
      end
      SEND: begin
        if (g_valid) begin
          tx_data_nxt    = g_data;
          tx_start_nxt   = 1'b1;
          req0_ready_nxt = gnt[0];
          req1_ready_nxt = gnt[1];
          last_nxt       = g_last;
          cnt_nxt        = '0;
          state_nxt      = HOLD;
        end else if (cnt == CNT_MAX) begin
          timeout_err_nxt = 1'b1;
          gnt_nxt         = 2'b00;
          ptr_nxt         = ~ptr;
          cnt_nxt         = '0;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Transmitter may not have raised busy yet; skip one cycle before sampling it.
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tx_busy) begin
          if (last_q) begin
            pkt_done_nxt = 1'b1;
            gnt_nxt      = 2'b00;
            ptr_nxt      = ~ptr;
            state_nxt    = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timeline reference model compared every cycle, plus
// directed scenarios with literal expectations on captured bytes, grants and timing.
module tb_uart_tx_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data  = 8'h00;
  logic       req0_last  = 1'b0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data  = 8'h00;
  logic       req1_last  = 1'b0;
  logic       req1_ready;
  logic       tx_busy    = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [1:0] gnt;
  logic       pkt_done;
  logic       timeout_err;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .gnt(gnt),
    .pkt_done(pkt_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Requester byte queues (written by the stimulus thread, consumed by read indices).
  logic [7:0] q0d[$];
  bit         q0l[$];
  logic [7:0] q1d[$];
  bit         q1l[$];
  int rd0 = 0, rd1 = 0, q1_base = 0;
  int busy_len = 0, busy_cnt = 0;

  // Cumulative observations of the DUT.
  int n_start = 0, n_rdy0 = 0, n_rdy1 = 0, n_done = 0, n_to = 0;
  int rdy1_cyc = 0, to_cyc = 0;
  logic [7:0] cap[$];
  logic [1:0] gseq[$];
  int st_cyc[$];
  logic [1:0] prev_gnt = 2'b00;

  // Baselines so each scenario looks only at its own events.
  int b_start, b_rdy0, b_rdy1, b_done, b_to, b_cap, b_gseq, b_st;

  task automatic baseline();
    b_start = n_start; b_rdy0 = n_rdy0; b_rdy1 = n_rdy1; b_done = n_done; b_to = n_to;
    b_cap = cap.size(); b_gseq = gseq.size(); b_st = st_cyc.size();
  endtask

  function automatic logic [7:0] cap_at(input int i);
    if (b_cap + i < cap.size()) return cap[b_cap + i];
    return 8'hxx;
  endfunction

  function automatic logic [1:0] gseq_at(input int i);
    if (b_gseq + i < gseq.size()) return gseq[b_gseq + i];
    return 2'bxx;
  endfunction

  function automatic int st_gap(input int i);
    if (b_st + i + 1 < st_cyc.size()) return st_cyc[b_st + i + 1] - st_cyc[b_st + i];
    return -1;
  endfunction

  task automatic load(input int r, input logic [7:0] d, input bit l);
    if (r == 0) begin q0d.push_back(d); q0l.push_back(l); end
    else begin q1d.push_back(d); q1l.push_back(l); end
  endtask

  // Requester/transmitter drivers and observation, all on the falling edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin n_start++; cap.push_back(tx_data); st_cyc.push_back(cyc); end
    if (req0_ready === 1'b1) begin n_rdy0++; rd0++; end
    if (req1_ready === 1'b1) begin n_rdy1++; rd1++; rdy1_cyc = cyc; end
    if (pkt_done === 1'b1) n_done++;
    if (timeout_err === 1'b1) begin n_to++; to_cyc = cyc; end
    if (gnt != 2'b00 && prev_gnt == 2'b00) gseq.push_back(gnt);
    prev_gnt = gnt;
    if (rd1 < q1_base) rd1 = q1_base;
    if (rst !== 1'b1) busy_cnt = 0;
    else if (tx_start === 1'b1) busy_cnt = busy_len;
    if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
    else tx_busy = 1'b0;
    req0_valid = rd0 < q0d.size();
    req0_data  = req0_valid ? q0d[rd0] : 8'h00;
    req0_last  = req0_valid ? q0l[rd0] : 1'b0;
    req1_valid = rd1 < q1d.size();
    req1_data  = req1_valid ? q1d[rd1] : 8'h00;
    req1_last  = req1_valid ? q1l[rd1] : 1'b0;
  end

  // Reference model: a timeline of arbitration and per-byte handshakes.
  logic [1:0] m_gnt = 2'b00;
  logic [7:0] m_data = 8'h00;
  bit m_start, m_rdy0, m_rdy1, m_done, m_to, m_ptr;

  task automatic m_edge(output bit alive);
    @(posedge clk);
    alive = (rst === 1'b1);
    m_start = 1'b0; m_rdy0 = 1'b0; m_rdy1 = 1'b0; m_done = 1'b0; m_to = 1'b0;
  endtask

  task automatic m_run();
    bit alive, w, lst, inpkt;
    int stall;
    forever begin
      m_edge(alive);
      if (!alive) return;
      if (en === 1'b1 && (req0_valid || req1_valid)) begin
        w = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        m_gnt = w ? 2'b10 : 2'b01;
        stall = 0;
        inpkt = 1'b1;
        while (inpkt) begin
          m_edge(alive);
          if (!alive) return;
          if (w ? req1_valid : req0_valid) begin
            m_data = w ? req1_data : req0_data;
            m_start = 1'b1; m_rdy0 = !w; m_rdy1 = w;
            lst = w ? req1_last : req0_last;
            stall = 0;
            m_edge(alive);
            if (!alive) return;
            m_edge(alive);
            if (!alive) return;
            while (tx_busy) begin
              m_edge(alive);
              if (!alive) return;
            end
            if (lst) begin m_done = 1'b1; m_gnt = 2'b00; m_ptr = !m_ptr; inpkt = 1'b0; end
          end else begin
            stall++;
            if (stall == TO) begin m_to = 1'b1; m_gnt = 2'b00; m_ptr = !m_ptr; inpkt = 1'b0; end
          end
        end
      end else begin
        m_gnt = 2'b00;
      end
    end
  endtask

  initial begin
    forever begin
      m_gnt = 2'b00; m_data = 8'h00; m_ptr = 1'b0;
      m_start = 1'b0; m_rdy0 = 1'b0; m_rdy1 = 1'b0; m_done = 1'b0; m_to = 1'b0;
      wait (rst === 1'b1);
      m_run();
    end
  end

  bit rs;
  always @(negedge clk) begin
    rs = (rst === 1'b1);
    check("gnt",         32'(gnt),         rs ? 32'(m_gnt)   : 32'd0);
    check("tx_data",     32'(tx_data),     rs ? 32'(m_data)  : 32'd0);
    check("tx_start",    32'(tx_start),    rs ? 32'(m_start) : 32'd0);
    check("req0_ready",  32'(req0_ready),  rs ? 32'(m_rdy0)  : 32'd0);
    check("req1_ready",  32'(req1_ready),  rs ? 32'(m_rdy1)  : 32'd0);
    check("pkt_done",    32'(pkt_done),    rs ? 32'(m_done)  : 32'd0);
    check("timeout_err", 32'(timeout_err), rs ? 32'(m_to)    : 32'd0);
  end

  task automatic wait_until(input string nm, input int want_done, input int want_to, input int budget);
    int k = 0;
    while ((n_done - b_done < want_done || n_to - b_to < want_to) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check({nm, "_wait"}, 32'(n_done - b_done >= want_done && n_to - b_to >= want_to), 32'd1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; busy_len = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b1;

    // Both requesters continuously valid with 2-byte packets.
    baseline(); busy_len = 1; en = 1'b1;
    load(0, 8'h10, 0); load(0, 8'h11, 1); load(0, 8'h12, 0); load(0, 8'h13, 1);
    load(1, 8'h20, 0); load(1, 8'h21, 1); load(1, 8'h22, 0); load(1, 8'h23, 1);
    wait_until("rr", 4, 0, 400);
    check("rr_g0", 32'(gseq_at(0)), 32'h1);
    check("rr_g1", 32'(gseq_at(1)), 32'h2);
    check("rr_g2", 32'(gseq_at(2)), 32'h1);
    check("rr_g3", 32'(gseq_at(3)), 32'h2);
    begin
      logic [7:0] exp_rr[8];
      exp_rr = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
      for (int i = 0; i < 8; i++) check("rr_byte", 32'(cap_at(i)), 32'(exp_rr[i]));
    end

    // req0 alone: A1,B2,C3 with a 4-cycle busy per byte.
    baseline(); busy_len = 4;
    load(0, 8'hA1, 0); load(0, 8'hB2, 0); load(0, 8'hC3, 1);
    wait_until("solo", 1, 0, 200);
    check("solo_starts", 32'(n_start - b_start), 32'd3);
    check("solo_rdy0", 32'(n_rdy0 - b_rdy0), 32'd3);
    check("solo_rdy1", 32'(n_rdy1 - b_rdy1), 32'd0);
    check("solo_b0", 32'(cap_at(0)), 32'hA1);
    check("solo_b1", 32'(cap_at(1)), 32'hB2);
    check("solo_b2", 32'(cap_at(2)), 32'hC3);
    check("solo_grants", 32'(gseq.size() - b_gseq), 32'd1);
    check("solo_gnt", 32'(gseq_at(0)), 32'h1);
    check("solo_gnt_after", 32'(gnt), 32'd0);

    // req1 sends one byte, then stalls until timeout; req0 waits meanwhile.
    baseline(); busy_len = 0;
    load(1, 8'h5A, 0);
    for (int k = 0; k < 60 && n_rdy1 - b_rdy1 < 1; k++) begin @(negedge clk); #1; end
    load(0, 8'h66, 1);
    wait_until("to", 0, 1, 100);
    check("to_delay", 32'(to_cyc - rdy1_cyc), 32'd10);
    check("to_starts", 32'(n_start - b_start), 32'd1);
    check("to_gnt", 32'(gnt), 32'd0);
    wait_until("to_next", 1, 1, 100);
    check("to_next_gnt", 32'(gseq_at(1)), 32'h1);
    check("to_next_byte", 32'(cap_at(1)), 32'h66);

    // en low blocks arbitration; a one-cycle en pulse grants a whole packet.
    baseline(); en = 1'b0;
    load(0, 8'h77, 1); load(1, 8'h88, 1);
    repeat (6) @(negedge clk);
    #1;
    check("en0_starts", 32'(n_start - b_start), 32'd0);
    check("en0_gnt", 32'(gnt), 32'd0);
    en = 1'b1;
    @(negedge clk); #1;
    en = 1'b0;
    wait_until("enp", 1, 0, 100);
    check("enp_gnt", 32'(gseq_at(0)), 32'h2);
    check("enp_byte", 32'(cap_at(0)), 32'h88);
    repeat (6) @(negedge clk);
    #1;
    check("enp_starts", 32'(n_start - b_start), 32'd1);

    // Reset during WAIT_TX of byte 2, with the pointer sitting at requester 1.
    baseline(); en = 1'b1; busy_len = 4;
    wait_until("pre", 1, 0, 100);
    check("pre_byte", 32'(cap_at(0)), 32'h77);
    baseline();
    load(1, 8'h31, 0); load(1, 8'h32, 0); load(1, 8'h33, 1);
    for (int k = 0; k < 100 && n_rdy1 - b_rdy1 < 2; k++) begin @(negedge clk); #1; end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_rdy1", 32'(req1_ready), 32'd0);
    check("mid_rst_sent", 32'(n_start - b_start), 32'd2);
    q1_base = q1d.size();
    load(1, 8'h41, 0); load(1, 8'h42, 1);
    baseline();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    wait_until("post", 1, 0, 100);
    check("post_gnt", 32'(gseq_at(0)), 32'h2);
    check("post_b0", 32'(cap_at(0)), 32'h41);
    check("post_b1", 32'(cap_at(1)), 32'h42);
    check("post_starts", 32'(n_start - b_start), 32'd2);
    load(0, 8'h51, 1); load(1, 8'h52, 1);
    wait_until("post_rr", 3, 0, 200);
    check("post_rr_g1", 32'(gseq_at(1)), 32'h2);
    check("post_rr_g2", 32'(gseq_at(2)), 32'h1);

    // Instant transmitter: 4-byte packet at the 3-cycle minimum byte period.
    baseline(); busy_len = 0;
    load(0, 8'h61, 0); load(0, 8'h62, 0); load(0, 8'h63, 0); load(0, 8'h64, 1);
    wait_until("fast", 1, 0, 100);
    check("fast_starts", 32'(n_start - b_start), 32'd4);
    for (int i = 0; i < 3; i++) check("fast_gap", 32'(st_gap(i)), 32'd3);
    check("fast_b3", 32'(cap_at(3)), 32'h64);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1000, max cycles a granted requester may hold valid low mid-packet (range 2..65535).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  arbitration enable.
- req0_valid  in  1  requester 0 byte available.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  requester 0 final byte of packet.
- req0_ready  out  1  one-cycle pulse: req0 byte consumed.
- req1_valid  in  1  requester 1 byte available.
- req1_data  in  8  requester 1 byte.
- req1_last  in  1  requester 1 final byte of packet.
- req1_ready  out  1  one-cycle pulse: req1 byte consumed.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmitter.
- tx_start  out  1  one-cycle start pulse to transmitter.
- gnt  out  2  one-hot current grant; 2'b00 when none.
- pkt_done  out  1  one-cycle pulse: packet completed.
- timeout_err  out  1  one-cycle pulse: grant released by timeout.
REQ-003 SHALL have all outputs registered.

Function
REQ-004 SHALL implement states IDLE, SEND, HOLD, WAIT_TX.
REQ-005 IDLE: when en=1 and any reqN_valid=1, SHALL set gnt to the winner and go to SEND next cycle; when en=0, SHALL stay in IDLE with gnt=00.
REQ-006 Winner: sole valid requester wins; if both are valid, the requester selected by the round-robin pointer wins.
REQ-007 Pointer SHALL move to the other requester after every grant release (pkt_done or timeout_err), regardless of which requester was served.
REQ-008 SEND with granted valid=1: SHALL register tx_data<=data, tx_start<=1, granted reqN_ready<=1, latch last, clear timeout counter, go to HOLD.
REQ-009 SEND with granted valid=0: SHALL increment the timeout counter; when it reaches TIMEOUT_CYCLES-1, SHALL pulse timeout_err, clear gnt, advance the pointer, and go to IDLE.
REQ-010 HOLD: SHALL deassert tx_start and reqN_ready and ignore tx_busy for this one cycle; go to WAIT_TX.
REQ-011 WAIT_TX: SHALL remain while tx_busy=1; on tx_busy=0, if the latched last=1 SHALL pulse pkt_done, clear gnt, advance the pointer, and go to IDLE; otherwise SHALL go to SEND.
REQ-012 tx_start and reqN_ready SHALL be high for exactly one cycle per byte, coincident, and only for the granted requester.
REQ-013 Grant SHALL be held for the whole packet; the non-granted requester's valid/data/last SHALL be ignored until release.
REQ-014 en falling mid-packet SHALL NOT abort the packet; en is sampled only in IDLE.
REQ-015 Single-byte packet (valid and last together) SHALL complete as SEND->HOLD->WAIT_TX->IDLE.
REQ-016 Minimum per-byte period SHALL be 3 cycles (SEND, HOLD, one WAIT_TX with tx_busy=0).
REQ-017 Earliest re-grant SHALL be the cycle after returning to IDLE; back-to-back packets from alternating requesters SHALL need no idle gap beyond the IDLE cycle.
REQ-018 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL NOT wrap.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE, pointer=requester 0, counter=0, and all outputs to 0 (tx_data=8'h00, gnt=00).
REQ-020 Reset mid-packet SHALL abort it with no further tx_start; after rst rises, behaviour SHALL be as from power-up.

Verification
REQ-021 Only req0 sends a 3-byte packet A1,B2,C3 with 4-cycle tx_busy per byte -> tx_data A1,B2,C3 in order, 3 tx_start pulses, 3 req0_ready pulses, one pkt_done, gnt=01 throughout, then 00.
REQ-022 Both requesters continuously valid with 2-byte packets -> grants alternate 01,10,01,10; req1 never preempts req0 mid-packet.
REQ-023 req1 granted, sends 1 byte, then drops valid (TIMEOUT_CYCLES=8) -> timeout_err pulses 8 cycles after entering the stall, gnt=00, next grant goes to req0 if valid.
REQ-024 en=0 with both valid -> no tx_start, gnt=00; en=1 for one cycle -> packet granted and completed even after en returns to 0.
REQ-025 rst low during WAIT_TX of byte 2 -> all outputs 0 immediately; after release, a fresh req1 packet is granted and the pointer is back at requester 0.
REQ-026 tx_busy held low (instant transmitter) with a 4-byte packet -> tx_start spacing exactly 3 cycles, never two consecutive cycles.
